// File: rtl/load_store_group_decoder_pkg.sv
// Shared encodings for the load/store group decoder: instruction fields, datapath
// select codes, register names and the internal control bundle.
package load_store_group_decoder_pkg;

    // Instruction group field (decoded upstream; listed here for the control mux)
    localparam logic [1:0] GROUP_ALU    = 2'b00;
    localparam logic [1:0] GROUP_LDS    = 2'b01;
    localparam logic [1:0] GROUP_BRANCH = 2'b10;
    localparam logic [1:0] GROUP_SYS    = 2'b11;

    localparam logic [1:0] LDSINCF_NONE     = 2'b00;
    localparam logic [1:0] LDSINCF_POST_INC = 2'b01;
    localparam logic [1:0] LDSINCF_PRE_DEC  = 2'b10;
    localparam logic [1:0] LDSINCF_RSVD     = 2'b11;

    localparam logic [1:0] LDSOPF_LD  = 2'b00;
    localparam logic [1:0] LDSOPF_ST  = 2'b01;
    localparam logic [1:0] LDSOPF_LDB = 2'b10;
    localparam logic [1:0] LDSOPF_STB = 2'b11;

    localparam logic [1:0] MODE_LDS_REG_MEM      = 2'b00;
    localparam logic [1:0] MODE_LDS_REG_FRAME    = 2'b01;
    localparam logic [1:0] MODE_LDS_REG_STACK    = 2'b10;
    localparam logic [1:0] MODE_LDS_REG_RETSTACK = 2'b11;

    localparam logic [3:0] ALU_OPX_NOP = 4'd0;
    localparam logic [3:0] ALU_OPX_ADD = 4'd1;
    localparam logic [3:0] ALU_OPX_SUB = 4'd2;
    localparam logic [3:0] ALU_OPX_MOV = 4'd3;
    localparam logic [3:0] ALU_OPX_AND = 4'd4;
    localparam logic [3:0] ALU_OPX_OR  = 4'd5;
    localparam logic [3:0] ALU_OPX_XOR = 4'd6;

    localparam logic ALUA_SRCX_REG_A = 1'b0;
    localparam logic ALUA_SRCX_TWO   = 1'b1;

    localparam logic [2:0] ALUB_SRCX_REG_B = 3'd0;
    localparam logic [2:0] ALUB_SRCX_U6_0  = 3'd1;
    localparam logic [2:0] ALUB_SRCX_S8_0  = 3'd2;
    localparam logic [2:0] ALUB_SRCX_ONE   = 3'd3;

    localparam logic [1:0] REGB_DINX_ALU_R    = 2'd0;
    localparam logic [1:0] REGB_DINX_DATA_BUS = 2'd1;

    localparam logic [2:0] REGA_ADDRX_ARGA = 3'd0;
    localparam logic [2:0] REGA_ADDRX_RFP  = 3'd1;
    localparam logic [2:0] REGA_ADDRX_RSP  = 3'd2;
    localparam logic [2:0] REGA_ADDRX_RRS  = 3'd3;

    localparam logic [1:0] REGB_ADDRX_ARGB = 2'd0;
    localparam logic [1:0] REGB_ADDRX_ARGA = 2'd1;

    localparam logic [1:0] REGA_BYTE_ENX_WORD = 2'd0;
    localparam logic [1:0] REGA_BYTE_ENX_LOW  = 2'd1;
    localparam logic [1:0] REGA_BYTE_ENX_HIGH = 2'd2;
    localparam logic [1:0] REGB_BYTE_ENX_WORD = 2'd0;
    localparam logic [1:0] REGB_BYTE_ENX_LOW  = 2'd1;
    localparam logic [1:0] REGB_BYTE_ENX_HIGH = 2'd2;

    localparam logic [1:0] DATA_BUSX_ALU_R = 2'd0;
    localparam logic [1:0] DATA_BUSX_REGB  = 2'd1;

    localparam logic [1:0] ADDR_BUSX_PC       = 2'd0;
    localparam logic [1:0] ADDR_BUSX_ALUA_DIN = 2'd1;
    localparam logic [1:0] ADDR_BUSX_ALU_R    = 2'd2;

    localparam logic [3:0] R0  = 4'd0;
    localparam logic [3:0] R1  = 4'd1;
    localparam logic [3:0] R2  = 4'd2;
    localparam logic [3:0] R3  = 4'd3;
    localparam logic [3:0] R4  = 4'd4;
    localparam logic [3:0] R5  = 4'd5;
    localparam logic [3:0] R6  = 4'd6;
    localparam logic [3:0] R7  = 4'd7;
    localparam logic [3:0] R8  = 4'd8;
    localparam logic [3:0] R9  = 4'd9;
    localparam logic [3:0] R10 = 4'd10;
    localparam logic [3:0] R11 = 4'd11;
    localparam logic [3:0] R12 = 4'd12;
    localparam logic [3:0] R13 = 4'd13;
    localparam logic [3:0] R14 = 4'd14;
    localparam logic [3:0] R15 = 4'd15;

    typedef struct packed {
        logic       rega_en;
        logic       regb_en;
        logic       rega_wen;
        logic       regb_wen;
        logic [3:0] alu_opx;
        logic       alua_srcx;
        logic [2:0] alub_srcx;
        logic [1:0] regb_dinx;
        logic [2:0] rega_addrx;
        logic [1:0] regb_addrx;
        logic [1:0] rega_byte_enx;
        logic [1:0] regb_byte_enx;
        logic [1:0] data_busx;
        logic       data_bus_oen;
        logic [1:0] addr_busx;
    } lds_ctrl_t;

    // Encoding-0 defaults double as the idle control word.
    function automatic lds_ctrl_t lds_ctrl_idle();
        lds_ctrl_t c;
        c = '0;
        return c;
    endfunction

endpackage

// File: rtl/load_store_group_decoder_if.sv
// Instruction field and control-select bundle between the load/store decoder and
// the control multiplexer.
interface load_store_group_decoder_if;
    logic [5:0] INSTRUCTION;
    logic       FETCH;
    logic       DECODE;
    logic       EXECUTE;
    logic       COMMIT;
    logic       REGA_EN;
    logic       REGB_EN;
    logic       REGA_WEN;
    logic       REGB_WEN;
    logic [3:0] ALU_OPX;
    logic       ALUA_SRCX;
    logic [2:0] ALUB_SRCX;
    logic [1:0] REGB_DINX;
    logic [2:0] REGA_ADDRX;
    logic [1:0] REGB_ADDRX;
    logic [1:0] REGA_BYTE_ENX;
    logic [1:0] REGB_BYTE_ENX;
    logic [1:0] DATA_BUSX;
    logic       DATA_BUS_OEN;
    logic [1:0] ADDR_BUSX;

    // Decoder side
    modport master (
        input  INSTRUCTION,
        output FETCH, DECODE, EXECUTE, COMMIT,
        output REGA_EN, REGB_EN, REGA_WEN, REGB_WEN,
        output ALU_OPX, ALUA_SRCX, ALUB_SRCX, REGB_DINX,
        output REGA_ADDRX, REGB_ADDRX, REGA_BYTE_ENX, REGB_BYTE_ENX,
        output DATA_BUSX, DATA_BUS_OEN, ADDR_BUSX
    );

    // Instruction source / control-mux side
    modport slave (
        output INSTRUCTION,
        input  FETCH, DECODE, EXECUTE, COMMIT,
        input  REGA_EN, REGB_EN, REGA_WEN, REGB_WEN,
        input  ALU_OPX, ALUA_SRCX, ALUB_SRCX, REGB_DINX,
        input  REGA_ADDRX, REGB_ADDRX, REGA_BYTE_ENX, REGB_BYTE_ENX,
        input  DATA_BUSX, DATA_BUS_OEN, ADDR_BUSX
    );
endinterface

// File: rtl/instruction_phase_decoder.sv
// Four-phase instruction sequencer: FETCH -> DECODE -> EXECUTE -> COMMIT ring,
// one-hot outputs, asynchronous active-low reset back to FETCH.
module instruction_phase_decoder (
    input  logic CLK,
    input  logic RESET,
    output logic FETCH,
    output logic DECODE,
    output logic EXECUTE,
    output logic COMMIT
);

    localparam logic [1:0] PH_FETCH   = 2'd0;
    localparam logic [1:0] PH_DECODE  = 2'd1;
    localparam logic [1:0] PH_EXECUTE = 2'd2;
    localparam logic [1:0] PH_COMMIT  = 2'd3;

    logic [1:0] phase_q;
    logic [1:0] phase_d;

    always_comb begin
        phase_d = PH_FETCH;
        case (phase_q)
            PH_FETCH:   phase_d = PH_DECODE;
            PH_DECODE:  phase_d = PH_EXECUTE;
            PH_EXECUTE: phase_d = PH_COMMIT;
            PH_COMMIT:  phase_d = PH_FETCH;
            default:    phase_d = PH_FETCH;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            phase_q <= PH_FETCH;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign FETCH   = (phase_q == PH_FETCH);
    assign DECODE  = (phase_q == PH_DECODE);
    assign EXECUTE = (phase_q == PH_EXECUTE);
    assign COMMIT  = (phase_q == PH_COMMIT);

endmodule

// File: rtl/load_store_group_decoder.sv
// Load/store group control decoder: latches instruction[13:8] when leaving FETCH
// and decodes it into datapath selects during EXECUTE and COMMIT.
module load_store_group_decoder
    import load_store_group_decoder_pkg::*;
(
    input  logic                            CLK,
    input  logic                            RESET,
    load_store_group_decoder_if.master      bus
);

    logic       fetch;
    logic       execute;
    logic       commit;
    logic [5:0] instr_q;
    logic [5:0] instr_d;

    logic [1:0] incf;
    logic [1:0] opf;
    logic [1:0] mode;
    logic       is_store;
    logic       is_byte;
    logic       offset_mode;
    logic       inc_dec;
    lds_ctrl_t  ctrl;

    instruction_phase_decoder u_phase (
        .CLK     (CLK),
        .RESET   (RESET),
        .FETCH   (fetch),
        .DECODE  (bus.DECODE),
        .EXECUTE (execute),
        .COMMIT  (commit)
    );

    assign bus.FETCH   = fetch;
    assign bus.EXECUTE = execute;
    assign bus.COMMIT  = commit;

    // Capture happens on the FETCH->DECODE edge only; the input is free afterwards.
    always_comb begin
        instr_d = instr_q;
        if (fetch) begin
            instr_d = bus.INSTRUCTION;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            instr_q <= 6'd0;
        end else begin
            instr_q <= instr_d;
        end
    end

    always_comb begin
        incf        = instr_q[5:4];
        opf         = instr_q[3:2];
        mode        = instr_q[1:0];
        is_store    = (opf == LDSOPF_ST) || (opf == LDSOPF_STB);
        is_byte     = (opf == LDSOPF_LDB) || (opf == LDSOPF_STB);
        offset_mode = (mode != MODE_LDS_REG_MEM);
        // In offset modes INCF carries offset bits, so it never means increment there.
        inc_dec     = !offset_mode &&
                      ((incf == LDSINCF_POST_INC) || (incf == LDSINCF_PRE_DEC));
    end

    always_comb begin
        ctrl = lds_ctrl_idle();
        if (execute || commit) begin
            ctrl.rega_byte_enx = REGA_BYTE_ENX_WORD;
            ctrl.regb_byte_enx = is_byte ? REGB_BYTE_ENX_LOW : REGB_BYTE_ENX_WORD;

            if (offset_mode) begin
                ctrl.alua_srcx  = ALUA_SRCX_REG_A;
                ctrl.alub_srcx  = ALUB_SRCX_U6_0;
                ctrl.addr_busx  = ADDR_BUSX_ALU_R;
                ctrl.regb_addrx = REGB_ADDRX_ARGA;
                case (mode)
                    MODE_LDS_REG_FRAME: begin
                        ctrl.rega_addrx = REGA_ADDRX_RFP;
                        ctrl.alu_opx    = ALU_OPX_SUB;
                    end
                    MODE_LDS_REG_STACK: begin
                        ctrl.rega_addrx = REGA_ADDRX_RSP;
                        ctrl.alu_opx    = ALU_OPX_ADD;
                    end
                    default: begin
                        ctrl.rega_addrx = REGA_ADDRX_RRS;
                        ctrl.alu_opx    = ALU_OPX_ADD;
                    end
                endcase
            end else begin
                ctrl.rega_addrx = REGA_ADDRX_ARGA;
                ctrl.addr_busx  = ADDR_BUSX_ALUA_DIN;
                ctrl.alu_opx    = ALU_OPX_MOV;
                ctrl.alub_srcx  = ALUB_SRCX_REG_B;
                ctrl.regb_addrx = REGB_ADDRX_ARGB;
                ctrl.alua_srcx  = inc_dec ? ALUA_SRCX_TWO : ALUA_SRCX_REG_A;
            end

            if (is_store) begin
                ctrl.data_busx    = DATA_BUSX_REGB;
                ctrl.data_bus_oen = 1'b1;
            end

            if (execute) begin
                ctrl.rega_en = 1'b1;
                ctrl.regb_en = is_store;
            end else begin
                // Pointer write-back for auto increment/decrement addressing.
                if (inc_dec) begin
                    ctrl.alu_opx = (incf == LDSINCF_POST_INC) ? ALU_OPX_ADD : ALU_OPX_SUB;
                end
                ctrl.rega_en  = inc_dec;
                ctrl.rega_wen = inc_dec;
                if (!is_store) begin
                    ctrl.regb_en   = 1'b1;
                    ctrl.regb_wen  = 1'b1;
                    ctrl.regb_dinx = REGB_DINX_DATA_BUS;
                end
            end
        end
    end

    assign bus.REGA_EN       = ctrl.rega_en;
    assign bus.REGB_EN       = ctrl.regb_en;
    assign bus.REGA_WEN      = ctrl.rega_wen;
    assign bus.REGB_WEN      = ctrl.regb_wen;
    assign bus.ALU_OPX       = ctrl.alu_opx;
    assign bus.ALUA_SRCX     = ctrl.alua_srcx;
    assign bus.ALUB_SRCX     = ctrl.alub_srcx;
    assign bus.REGB_DINX     = ctrl.regb_dinx;
    assign bus.REGA_ADDRX    = ctrl.rega_addrx;
    assign bus.REGB_ADDRX    = ctrl.regb_addrx;
    assign bus.REGA_BYTE_ENX = ctrl.rega_byte_enx;
    assign bus.REGB_BYTE_ENX = ctrl.regb_byte_enx;
    assign bus.DATA_BUSX     = ctrl.data_busx;
    assign bus.DATA_BUS_OEN  = ctrl.data_bus_oen;
    assign bus.ADDR_BUSX     = ctrl.addr_busx;

endmodule

// File: tb/tb_load_store_group_decoder.sv
// Directed + random bench for load_store_group_decoder against a phase-counting
// behavioural model of the load/store control rules.
module tb_load_store_group_decoder;
    import load_store_group_decoder_pkg::*;

    logic CLK;
    logic RESET;
    int   checks;
    int   errors;

    int         m_phase;   // 0 FETCH, 1 DECODE, 2 EXECUTE, 3 COMMIT
    logic [5:0] m_instr;
    logic [5:0] drv;
    string      ctx;

    load_store_group_decoder_if bus ();

    load_store_group_decoder dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       ph[4];
        logic       rega_en, regb_en, rega_wen, regb_wen;
        logic [3:0] alu;
        logic       alua;
        logic [2:0] alub;
        logic [1:0] dinx;
        logic [2:0] a_addr;
        logic [1:0] b_addr;
        logic [1:0] a_byte, b_byte;
        logic [1:0] dbus;
        logic       oen;
        logic [1:0] abus;
    } exp_t;

    function automatic exp_t model(input int ph, input logic [5:0] ins);
        exp_t e;
        logic [1:0] incf = ins[5:4];
        logic [1:0] op   = ins[3:2];
        logic [1:0] mode = ins[1:0];
        bit load    = (op == LDSOPF_LD) || (op == LDSOPF_LDB);
        bit byte_op = (op == LDSOPF_LDB) || (op == LDSOPF_STB);
        bit autoinc = (mode == MODE_LDS_REG_MEM) &&
                      (incf == LDSINCF_POST_INC || incf == LDSINCF_PRE_DEC);
        for (int i = 0; i < 4; i++) e.ph[i] = (i == ph);
        e.rega_en = 0; e.regb_en = 0; e.rega_wen = 0; e.regb_wen = 0;
        e.alu = 0; e.alua = 0; e.alub = 0; e.dinx = 0; e.a_addr = 0; e.b_addr = 0;
        e.a_byte = 0; e.b_byte = 0; e.dbus = 0; e.oen = 0; e.abus = 0;
        if (ph < 2) return e;
        case (mode)
            MODE_LDS_REG_MEM: begin
                e.alu = ALU_OPX_MOV; e.a_addr = REGA_ADDRX_ARGA; e.abus = ADDR_BUSX_ALUA_DIN;
                e.alub = ALUB_SRCX_REG_B; e.b_addr = REGB_ADDRX_ARGB;
                e.alua = autoinc ? ALUA_SRCX_TWO : ALUA_SRCX_REG_A;
            end
            MODE_LDS_REG_FRAME: begin
                e.alu = ALU_OPX_SUB; e.a_addr = REGA_ADDRX_RFP;
            end
            MODE_LDS_REG_STACK: begin
                e.alu = ALU_OPX_ADD; e.a_addr = REGA_ADDRX_RSP;
            end
            default: begin
                e.alu = ALU_OPX_ADD; e.a_addr = REGA_ADDRX_RRS;
            end
        endcase
        if (mode != MODE_LDS_REG_MEM) begin
            e.alua = ALUA_SRCX_REG_A; e.alub = ALUB_SRCX_U6_0;
            e.abus = ADDR_BUSX_ALU_R; e.b_addr = REGB_ADDRX_ARGA;
        end
        e.a_byte = REGA_BYTE_ENX_WORD;
        e.b_byte = byte_op ? REGB_BYTE_ENX_LOW : REGB_BYTE_ENX_WORD;
        if (!load) begin
            e.dbus = DATA_BUSX_REGB; e.oen = 1;
        end
        if (ph == 2) begin
            e.rega_en = 1; e.regb_en = !load;
        end else begin
            e.regb_en = load; e.regb_wen = load;
            e.dinx = load ? REGB_DINX_DATA_BUS : REGB_DINX_ALU_R;
            e.rega_en = autoinc; e.rega_wen = autoinc;
            if (autoinc) e.alu = (incf == LDSINCF_POST_INC) ? ALU_OPX_ADD : ALU_OPX_SUB;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s %s: observed %0h expected %0h", ctx, tag, obs, exp);
        end
    endtask

    task automatic check_all();
        exp_t e;
        e = model(m_phase, m_instr);
        ctx = $sformatf("[t=%0t ph=%0d ins=%06b]", $time, m_phase, m_instr);
        chk("FETCH", {3'b0, bus.FETCH}, {3'b0, e.ph[0]});
        chk("DECODE", {3'b0, bus.DECODE}, {3'b0, e.ph[1]});
        chk("EXECUTE", {3'b0, bus.EXECUTE}, {3'b0, e.ph[2]});
        chk("COMMIT", {3'b0, bus.COMMIT}, {3'b0, e.ph[3]});
        chk("REGA_EN", {3'b0, bus.REGA_EN}, {3'b0, e.rega_en});
        chk("REGB_EN", {3'b0, bus.REGB_EN}, {3'b0, e.regb_en});
        chk("REGA_WEN", {3'b0, bus.REGA_WEN}, {3'b0, e.rega_wen});
        chk("REGB_WEN", {3'b0, bus.REGB_WEN}, {3'b0, e.regb_wen});
        chk("ALU_OPX", bus.ALU_OPX, e.alu);
        chk("ALUA_SRCX", {3'b0, bus.ALUA_SRCX}, {3'b0, e.alua});
        chk("ALUB_SRCX", {1'b0, bus.ALUB_SRCX}, {1'b0, e.alub});
        chk("REGB_DINX", {2'b0, bus.REGB_DINX}, {2'b0, e.dinx});
        chk("REGA_ADDRX", {1'b0, bus.REGA_ADDRX}, {1'b0, e.a_addr});
        chk("REGB_ADDRX", {2'b0, bus.REGB_ADDRX}, {2'b0, e.b_addr});
        chk("REGA_BYTE_ENX", {2'b0, bus.REGA_BYTE_ENX}, {2'b0, e.a_byte});
        chk("REGB_BYTE_ENX", {2'b0, bus.REGB_BYTE_ENX}, {2'b0, e.b_byte});
        chk("DATA_BUSX", {2'b0, bus.DATA_BUSX}, {2'b0, e.dbus});
        chk("DATA_BUS_OEN", {3'b0, bus.DATA_BUS_OEN}, {3'b0, e.oen});
        chk("ADDR_BUSX", {2'b0, bus.ADDR_BUSX}, {2'b0, e.abus});
    endtask

    // One clock: update the model on the edge, check at the following falling edge.
    task automatic tick();
        @(posedge CLK);
        if (RESET) begin
            if (m_phase == 0) m_instr = drv;
            m_phase = (m_phase + 1) % 4;
        end
        @(negedge CLK);
        check_all();
    endtask

    // Called in FETCH; returns in the next FETCH. INSTRUCTION is scrambled after capture.
    task automatic run_instr(input logic [5:0] ins);
        drv = ins;
        bus.INSTRUCTION = drv;
        tick();
        drv = 6'($urandom);
        bus.INSTRUCTION = drv;
        repeat (3) tick();
    endtask

    initial begin
        logic [5:0] directed [10];
        checks  = 0;
        errors  = 0;
        m_phase = 0;
        m_instr = 6'd0;
        drv     = 6'd0;
        RESET   = 1'b0;
        bus.INSTRUCTION = 6'd0;

        repeat (2) @(negedge CLK);
        check_all();                          // reset state
        RESET = 1'b1;

        // Three full cycles with a live changing input, before any directed instruction
        for (int i = 0; i < 12; i++) begin
            drv = 6'($urandom);
            bus.INSTRUCTION = drv;
            tick();
        end

        directed[0] = {LDSINCF_NONE,     LDSOPF_LD,  MODE_LDS_REG_MEM};
        directed[1] = {LDSINCF_PRE_DEC,  LDSOPF_LD,  MODE_LDS_REG_MEM};
        directed[2] = {LDSINCF_POST_INC, LDSOPF_LD,  MODE_LDS_REG_MEM};
        directed[3] = {LDSINCF_NONE,     LDSOPF_ST,  MODE_LDS_REG_MEM};
        directed[4] = {2'b10,            LDSOPF_LD,  MODE_LDS_REG_FRAME};
        directed[5] = {2'b10,            LDSOPF_LD,  MODE_LDS_REG_STACK};
        directed[6] = {2'b10,            LDSOPF_LD,  MODE_LDS_REG_RETSTACK};
        directed[7] = {LDSINCF_RSVD,     LDSOPF_LDB, MODE_LDS_REG_MEM};
        directed[8] = {LDSINCF_POST_INC, LDSOPF_STB, MODE_LDS_REG_MEM};
        directed[9] = {LDSINCF_PRE_DEC,  LDSOPF_STB, MODE_LDS_REG_STACK};
        for (int i = 0; i < 10; i++) run_instr(directed[i]);

        // Reset in the middle of EXECUTE
        drv = {LDSINCF_POST_INC, LDSOPF_ST, MODE_LDS_REG_MEM};
        bus.INSTRUCTION = drv;
        repeat (2) tick();
        RESET = 1'b0;
        #1;
        m_phase = 0;
        m_instr = 6'd0;
        check_all();
        @(posedge CLK);
        @(negedge CLK);
        check_all();
        RESET = 1'b1;
        run_instr({LDSINCF_PRE_DEC, LDSOPF_LD, MODE_LDS_REG_MEM});

        for (int i = 0; i < 40; i++) run_instr(6'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_group_decoder.md
Name: load_store_group_decoder

Overview:
- Control decoder for the load/store instruction group. It contains the four-phase instruction sequencer (FETCH, DECODE, EXECUTE, COMMIT).
- It decodes instruction bits [13:8] into register-file, ALU, data-source and bus-control selects.
- Its outputs feed the control multiplexer, which applies them only when the group field selects load/store. This block never sees the group bits.

Parameters:
- none

Ports:
- CLK  in  1  system clock; all state updates on the rising edge
- RESET  in  1  asynchronous, active-low reset
- INSTRUCTION  in  6  instruction[13:8] = {INCF[1:0], OPF[1:0], MODE[1:0]}
- FETCH, DECODE, EXECUTE, COMMIT  out  1 each  one-hot phase indicators
- REGA_EN, REGB_EN  out  1 each  register port read/access enables
- REGA_WEN, REGB_WEN  out  1 each  register port write enables
- ALU_OPX  out  4  ALU operation select
- ALUA_SRCX  out  1  ALU A source: REG_A or TWO
- ALUB_SRCX  out  3  ALU B source select
- REGB_DINX  out  2  register port B write-data source
- REGA_ADDRX  out  3  register port A address select (ARGA / RFP / RSP / RRS)
- REGB_ADDRX  out  2  register port B address select
- REGA_BYTE_ENX, REGB_BYTE_ENX  out  2 each  byte-lane select
- DATA_BUSX  out  2  data-bus source select
- DATA_BUS_OEN  out  1  data-bus drive enable, active-high
- ADDR_BUSX  out  2  address-bus source select

Behaviour:
- Field encodings:
  - INCF: NONE=00, POST_INC=01, PRE_DEC=10, 11 reserved (treated as NONE).
  - OPF: LD=00, ST=01, LDB=10, STB=11.
  - MODE: REG_MEM=00, REG_FRAME=01, REG_STACK=10, REG_RETSTACK=11.
  - In the offset modes, INCF forms the upper bits of the U6 offset and is ignored for increment purposes.
- Phase sequencer:
  - Reset (asynchronous) forces FETCH=1, others 0.
  - Each rising edge advances FETCH→DECODE→EXECUTE→COMMIT→FETCH.
  - Exactly one phase output is high at any time.
- The 6-bit field is latched on the FETCH→DECODE edge. Reset clears the latch to 0. Decoding uses only the latched value, so INSTRUCTION may change after that edge.
- Idle/default state (reset, FETCH, DECODE):
  - All EN/WEN and DATA_BUS_OEN are 0.
  - Every mux select is at its encoding 0 default.
- Outputs are combinational from latched field and phase. They are valid throughout EXECUTE and COMMIT, with no added latency.
- EXECUTE, REG_MEM:
  - REGA_EN=1, REGA_ADDRX=ARGA, ADDR_BUSX=ALUA_DIN, ALU_OPX=MOV, ALUB_SRCX=REG_B, REGB_ADDRX=ARGB.
  - ALUA_SRCX=REG_A when INCF=NONE; TWO for POST_INC/PRE_DEC.
- EXECUTE, offset modes:
  - Common: REGA_EN=1, ALUA_SRCX=REG_A, ALUB_SRCX=U6_0, ADDR_BUSX=ALU_R, REGB_ADDRX=ARGA.
  - FRAME: REGA_ADDRX=RFP, ALU_OPX=SUB.
  - STACK: REGA_ADDRX=RSP, ALU_OPX=ADD.
  - RETSTACK: REGA_ADDRX=RRS, ALU_OPX=ADD.
- EXECUTE, by operation:
  - LD/LDB: REGB_EN=0, all WEN=0.
  - ST/STB: REGB_EN=1, WEN=0, DATA_BUSX=REGB, DATA_BUS_OEN=1.
- COMMIT:
  - Mux selects hold their EXECUTE values.
  - Exception: with INC/DEC in REG_MEM, ALU_OPX=ADD for POST_INC and SUB for PRE_DEC (pointer update).
  - LD/LDB: REGB_EN=1, REGB_WEN=1, REGB_DINX=DATA_BUS.
  - ST/STB: REGB_EN=0, REGB_WEN=0, DATA_BUS_OEN=1 held.
  - REG_MEM with POST_INC/PRE_DEC: REGA_EN=1, REGA_WEN=1. Otherwise REGA_EN=0, REGA_WEN=0.
- Byte ops (LDB/STB): REGB_BYTE_ENX=LOW. LD/ST: WORD. REGA_BYTE_ENX is always WORD. Increment size is always TWO.
- Reset asserted mid-instruction: immediate return to FETCH with idle outputs; the partial instruction is abandoned.

Decomposition:
- Shared constants package holds:
  - GROUP_*, LDSINCF_*, LDSOPF_*, MODE_LDS_* field encodings
  - ALU_OPX_*, ALUA_SRCX_*, ALUB_SRCX_*, REGA_ADDRX_*, REGB_ADDRX_*, REGB_DINX_*, *_BYTE_ENX_*, DATA_BUSX_*, ADDR_BUSX_* select encodings
  - R0–R15 register names
- One sub-module, instruction_phase_decoder: CLK, RESET → FETCH/DECODE/EXECUTE/COMMIT ring counter.
- Decode logic lives in the top module.

Test Plan:
- Reset, release, run 3 full cycles → phases rotate FETCH,DECODE,EXECUTE,COMMIT; all enables 0 outside EXECUTE/COMMIT.
- LD Ra,(Rb) {INCF=NONE,OPF=LD,MODE=REG_MEM} →
  - EXECUTE: REGA_EN=1, REGB_EN=0, WEN=0/0, ALUA=REG_A, ALUB=REG_B, MOV, ADDR=ALUA_DIN, REGA_ADDRX=ARGA.
  - COMMIT: REGA_EN=0, REGB_EN=1, REGA_WEN=0, REGB_WEN=1.
- LD with PRE_DEC, then POST_INC →
  - EXECUTE: ALUA=TWO, ALUB=REG_B, MOV, ADDR=ALUA_DIN.
  - COMMIT: REGA_EN, REGB_EN, REGA_WEN, REGB_WEN all =1.
- ST (Rb),Ra {NONE,ST,REG_MEM} →
  - EXECUTE: REGA_EN=1, REGB_EN=1, WEN=0/0, ALUA=REG_A, MOV, ADDR=ALUA_DIN, DATA_BUS_OEN=1.
  - COMMIT: all EN/WEN=0.
- LD in FRAME, STACK, RETSTACK, offset 0b100101 →
  - EXECUTE: ALUB=U6_0, ADDR=ALU_R, REGA_EN=1, with SUB/RFP, ADD/RSP, ADD/RRS respectively.
  - COMMIT: REGB_EN=1, REGB_WEN=1, REGA_EN=0, REGA_WEN=0.
- Assert RESET during EXECUTE → FETCH=1 immediately, all enables 0; next instruction decodes normally.
